// File: rtl/xnor_pkg.sv
// Shared types for the XNOR-conv job scheduler and its helper slots.
package xnor_pkg;
  localparam int ACT_W     = 32;
  localparam int WGT_W     = 25;
  localparam int OUT_W     = 6;
  localparam int JOB_TAG_W = 32;  // widest tag a job can carry; top narrows to TAG_W

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_W  = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } hp_state_e;

  typedef struct packed {
    logic [ACT_W-1:0]     act;
    logic [WGT_W-1:0]     wgt;
    logic [JOB_TAG_W-1:0] tag;
  } job_t;
endpackage

// File: rtl/xnor_helper_slot.sv
// One helper lane: job FSM, latency counter, drive registers, weight cache and result register.
module xnor_helper_slot
  import xnor_pkg::*;
#(
  parameter int HELPER_LAT = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    accept_i,
  input  job_t                    job_i,
  input  logic                    retire_i,
  input  logic signed [OUT_W-1:0] pe_out_c_i,
  output hp_state_e               state_o,
  output logic                    weight_valid_o,
  output logic [ACT_W-1:0]        pe_in_a_o,
  output logic [WGT_W-1:0]        pe_in_b_o,
  output logic signed [OUT_W-1:0] res_data_o,
  output logic [JOB_TAG_W-1:0]    res_tag_o
);
  localparam int CNT_W = (HELPER_LAT > 1) ? $clog2(HELPER_LAT) : 1;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(HELPER_LAT - 1);

  hp_state_e               state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  job_t                    job_q, job_d;
  logic [WGT_W-1:0]        cache_q, cache_d;
  logic                    cache_vld_q, cache_vld_d;
  logic signed [OUT_W-1:0] res_q, res_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      job_q       <= '0;
      cache_q     <= '0;
      cache_vld_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      job_q       <= job_d;
      cache_q     <= cache_d;
      cache_vld_q <= cache_vld_d;
      res_q       <= res_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    job_d       = job_q;
    cache_d     = cache_q;
    cache_vld_d = cache_vld_q;
    res_d       = res_q;
    if (clear) begin
      state_d     = IDLE;
      cache_vld_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_i) begin
            job_d   = job_i;
            cnt_d   = LAT_M1;
            state_d = (cache_vld_q && (cache_q == job_i.wgt)) ? COMPUTE : LOAD_W;
          end
        end
        LOAD_W: begin
          cache_d     = job_q.wgt;
          cache_vld_d = 1'b1;
          cnt_d       = LAT_M1;
          state_d     = COMPUTE;
        end
        COMPUTE: begin
          if (cnt_q == '0) begin
            res_d   = pe_out_c_i;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          if (retire_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The tag stays in the drive register until the next accept, which cannot precede retirement.
  assign state_o        = state_q;
  assign weight_valid_o = (state_q == LOAD_W);
  assign pe_in_a_o      = job_q.act;
  assign pe_in_b_o      = job_q.wgt;
  assign res_data_o     = res_q;
  assign res_tag_o      = job_q.tag;
endmodule

// File: rtl/xnor_conv_scheduler.sv
// Round-robin dispatch of XNOR-conv jobs to NUMHELPER helper slots with in-order retirement.
module xnor_conv_scheduler
  import xnor_pkg::*;
#(
  parameter int NUMHELPER  = 4,
  parameter int HELPER_LAT = 2,
  parameter int TAG_W      = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           job_valid,
  output logic                           job_ready,
  input  logic [ACT_W-1:0]               job_act,
  input  logic [WGT_W-1:0]               job_wgt,
  input  logic [TAG_W-1:0]               job_tag,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic signed [OUT_W-1:0]        res_data,
  output logic [TAG_W-1:0]               res_tag,
  output logic [NUMHELPER-1:0]           hp_weight_valid,
  output logic [ACT_W*NUMHELPER-1:0]     hp_pe_in_a,
  output logic [WGT_W*NUMHELPER-1:0]     hp_pe_in_b,
  input  logic [OUT_W*NUMHELPER-1:0]     hp_pe_out_c,
  output logic                           busy
);
  localparam int PTR_W = $clog2(NUMHELPER);

  logic [PTR_W-1:0]        dptr_q, dptr_d, rptr_q, rptr_d;
  hp_state_e               st    [NUMHELPER];
  logic signed [OUT_W-1:0] rdata [NUMHELPER];
  logic [JOB_TAG_W-1:0]    rtag  [NUMHELPER];
  logic [NUMHELPER-1:0]    acc_v, ret_v, busy_v;
  logic                    accept, retire;
  job_t                    job;

  always_comb begin
    job     = '0;
    job.act = job_act;
    job.wgt = job_wgt;
    job.tag = JOB_TAG_W'(job_tag);
  end

  // Gating with reset keeps job_ready low while reset is held, even though every slot is IDLE.
  assign job_ready = reset & ~clear & (st[dptr_q] == IDLE);
  assign res_valid = (st[rptr_q] == DONE);
  assign res_data  = rdata[rptr_q];
  assign res_tag   = TAG_W'(rtag[rptr_q]);
  assign accept    = job_valid & job_ready;
  assign retire    = res_valid & res_ready;
  assign busy      = |busy_v;

  always_comb begin
    dptr_d = dptr_q;
    rptr_d = rptr_q;
    if (clear) begin
      dptr_d = '0;
      rptr_d = '0;
    end else begin
      if (accept) dptr_d = dptr_q + PTR_W'(1);
      if (retire) rptr_d = rptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dptr_q <= '0;
      rptr_q <= '0;
    end else begin
      dptr_q <= dptr_d;
      rptr_q <= rptr_d;
    end
  end

  for (genvar i = 0; i < NUMHELPER; i++) begin : g_slot
    assign acc_v[i]  = accept & (dptr_q == PTR_W'(i));
    assign ret_v[i]  = retire & (rptr_q == PTR_W'(i));
    assign busy_v[i] = (st[i] != IDLE);

    xnor_helper_slot #(
      .HELPER_LAT (HELPER_LAT)
    ) u_slot (
      .clock          (clock),
      .reset          (reset),
      .clear          (clear),
      .accept_i       (acc_v[i]),
      .job_i          (job),
      .retire_i       (ret_v[i]),
      .pe_out_c_i     (hp_pe_out_c[OUT_W*i +: OUT_W]),
      .state_o        (st[i]),
      .weight_valid_o (hp_weight_valid[i]),
      .pe_in_a_o      (hp_pe_in_a[ACT_W*i +: ACT_W]),
      .pe_in_b_o      (hp_pe_in_b[WGT_W*i +: WGT_W]),
      .res_data_o     (rdata[i]),
      .res_tag_o      (rtag[i])
    );
  end
endmodule
